// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: reset-time NOP sweep, streaming program load,
// and a registered, stall-aware byte-addressed fetch port with fault flags.
module instr_mem_loadable #(
    parameter int               DEPTH    = 64,
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  NOP_WORD = 32'h0000_0013,
    localparam int              AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start,
    input  logic             load_valid,
    input  logic [XLEN-1:0]  load_data,
    input  logic             load_last,
    output logic             load_ready,
    output logic [AW:0]      load_count,
    input  logic [31:0]      pc_in,
    input  logic             fetch_en,
    output logic [XLEN-1:0]  instr_out,
    output logic             instr_valid,
    output logic             misaligned,
    output logic             out_of_range,
    output logic             mem_ready
);

    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_INDEX = AW'(DEPTH - 1);
    localparam logic [31:0]   BYTE_LIMIT = 32'(4 * DEPTH);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t             state;
    logic [AW-1:0]      clr_ptr;
    logic [XLEN-1:0]    mem [DEPTH];

    logic               load_xfer;
    logic               mem_we;
    logic [AW-1:0]      mem_waddr;
    logic [XLEN-1:0]    mem_wdata;

    logic [AW-1:0]      fetch_index;
    logic               fetch_misaligned;
    logic               fetch_oor;
    logic               fetch_active;

    assign load_ready = (state == ST_LOAD) && (load_count < FULL_COUNT);
    assign mem_ready  = (state == ST_RUN);

    // A restart in the same cycle as a valid word discards that word.
    assign load_xfer = load_valid && load_ready && !load_start;

    assign fetch_index      = pc_in[AW+1:2];
    assign fetch_misaligned = (pc_in[1:0] != 2'b00);
    assign fetch_oor        = (pc_in >= BYTE_LIMIT);
    assign fetch_active     = (state == ST_RUN) && !load_start;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = NOP_WORD;
        if (state == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr;
        end else if (load_xfer) begin
            mem_we    = 1'b1;
            mem_waddr = load_count[AW-1:0];
            mem_wdata = load_data;
        end
    end

    // NOTE: the array has no reset; the CLEAR sweep initialises it instead, so it maps to RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_CLEAR;
            clr_ptr    <= '0;
            load_count <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == LAST_INDEX) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (load_start) begin
                        state      <= ST_LOAD;
                        load_count <= '0;
                    end
                end
                ST_LOAD: begin
                    if (load_start) begin
                        load_count <= '0;
                    end else if (load_xfer) begin
                        load_count <= load_count + 1'b1;
                        if (load_last || (load_count == FULL_COUNT - 1'b1)) begin
                            state <= ST_RUN;
                        end
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_out    <= NOP_WORD;
            instr_valid  <= 1'b0;
            misaligned   <= 1'b0;
            out_of_range <= 1'b0;
        end else if (fetch_active) begin
            if (fetch_en) begin
                instr_out    <= (fetch_misaligned || fetch_oor) ? NOP_WORD : mem[fetch_index];
                instr_valid  <= 1'b1;
                misaligned   <= fetch_misaligned;
                out_of_range <= fetch_oor;
            end
        end else begin
            instr_out    <= NOP_WORD;
            instr_valid  <= 1'b0;
            misaligned   <= 1'b0;
            out_of_range <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed self-checking bench for instr_mem_loadable (DEPTH=64, XLEN=32).
module tb_instr_mem_loadable;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        load_start;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic [6:0]  load_count;
    logic [31:0] pc_in;
    logic        fetch_en;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        misaligned;
    logic        out_of_range;
    logic        mem_ready;

    int tests_run;
    int tests_failed;

    instr_mem_loadable dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_start   (load_start),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_last    (load_last),
        .load_ready   (load_ready),
        .load_count   (load_count),
        .pc_in        (pc_in),
        .fetch_en     (fetch_en),
        .instr_out    (instr_out),
        .instr_valid  (instr_valid),
        .misaligned   (misaligned),
        .out_of_range (out_of_range),
        .mem_ready    (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge; outputs are sampled and inputs changed 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc);
        pc_in    = pc;
        fetch_en = 1'b1;
        step();
    endtask

    task automatic wait_ready(input string tag);
        int cyc;
        cyc = 0;
        while (!mem_ready && cyc < 200) begin
            step();
            cyc++;
        end
        check(tag, 32'(cyc), 32'd64);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_instr"}, instr_out, NOP);
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_mis"}, 32'(misaligned), 32'd0);
        check({tag, "_oor"}, 32'(out_of_range), 32'd0);
        check({tag, "_lready"}, 32'(load_ready), 32'd0);
        check({tag, "_mready"}, 32'(mem_ready), 32'd0);
        check({tag, "_lcount"}, 32'(load_count), 32'd0);
    endtask

    logic [31:0] prog [3];

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        prog[0] = 32'h4030_8133;
        prog[1] = 32'h0051_71B3;
        prog[2] = 32'h00A1_0693;

        rst_n      = 1'b0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = 32'h0;
        load_last  = 1'b0;
        pc_in      = 32'h0;
        fetch_en   = 1'b0;

        // Reset state and sweep length.
        repeat (3) step();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        wait_ready("clear_cycles");
        check("run_lready", 32'(load_ready), 32'd0);

        fetch(32'h20);
        check("f20_instr", instr_out, NOP);
        check("f20_valid", 32'(instr_valid), 32'd1);
        check("f20_mis", 32'(misaligned), 32'd0);
        check("f20_oor", 32'(out_of_range), 32'd0);

        // Short program with gaps on load_valid; gap cycles carry junk data.
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check("load_valid_cleared", 32'(instr_valid), 32'd0);
        check("load_ready_up", 32'(load_ready), 32'd1);
        check("load_mready_low", 32'(mem_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b0;
            load_data  = 32'hDEAD_BEEF;
            step();
            check("gap_count", 32'(load_count), 32'(i));
            load_valid = 1'b1;
            load_data  = prog[i];
            load_last  = (i == 2);
            step();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        check("short_count", 32'(load_count), 32'd3);
        check("short_run", 32'(mem_ready), 32'd1);
        check("short_lready", 32'(load_ready), 32'd0);

        fetch(32'h0);
        check("p0", instr_out, prog[0]);
        fetch(32'h4);
        check("p1", instr_out, prog[1]);
        fetch(32'h8);
        check("p2", instr_out, prog[2]);
        check("p2_valid", 32'(instr_valid), 32'd1);
        fetch(32'hC);
        check("p3_untouched", instr_out, NOP);

        // Address faults and last in-range word.
        fetch(32'h6);
        check("mis_instr", instr_out, NOP);
        check("mis_flag", 32'(misaligned), 32'd1);
        check("mis_oor", 32'(out_of_range), 32'd0);
        check("mis_valid", 32'(instr_valid), 32'd1);
        fetch(32'h100);
        check("oor_instr", instr_out, NOP);
        check("oor_flag", 32'(out_of_range), 32'd1);
        check("oor_mis", 32'(misaligned), 32'd0);
        fetch(32'hFC);
        check("top_oor", 32'(out_of_range), 32'd0);
        fetch(32'h102);
        check("both_instr", instr_out, NOP);
        check("both_mis", 32'(misaligned), 32'd1);
        check("both_oor", 32'(out_of_range), 32'd1);
        fetch_en = 1'b0;
        pc_in    = 32'h0;
        step();
        check("stall_flags_mis", 32'(misaligned), 32'd1);
        check("stall_flags_oor", 32'(out_of_range), 32'd1);

        // Stall holds the word fetched from 0x0 while pc moves on.
        fetch(32'h0);
        check("stall_pre", instr_out, prog[0]);
        fetch_en = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            pc_in = (i == 1) ? 32'h4 : 32'h8;
            step();
        end
        check("stall_hold", instr_out, prog[0]);
        check("stall_valid", 32'(instr_valid), 32'd1);
        fetch(32'h8);
        check("stall_resume", instr_out, prog[2]);

        // Full-depth load without load_last.
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i == 63) begin
                check("full_pre_count", 32'(load_count), 32'd63);
                check("full_pre_ready", 32'(load_ready), 32'd1);
            end
            load_valid = 1'b1;
            load_data  = 32'h1000_0000 + 32'(i);
            step();
        end
        check("full_count", 32'(load_count), 32'd64);
        check("full_ready_low", 32'(load_ready), 32'd0);
        check("full_run", 32'(mem_ready), 32'd1);
        load_data = 32'h0BAD_0BAD;
        step();
        load_valid = 1'b0;
        check("full_sat", 32'(load_count), 32'd64);
        fetch(32'h0);
        check("full_w0", instr_out, 32'h1000_0000);
        fetch(32'hFC);
        check("full_w63", instr_out, 32'h1000_003F);
        fetch(32'h80);
        check("full_w32", instr_out, 32'h1000_0020);

        // Reset in the middle of a load.
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        load_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            load_data = 32'hA000_0000 + 32'(i);
            step();
        end
        load_valid = 1'b0;
        check("mid_count", 32'(load_count), 32'd10);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        step();
        step();
        rst_n = 1'b1;
        wait_ready("reclear_cycles");
        fetch(32'h0);
        check("rc_w0", instr_out, NOP);
        check("rc_valid", 32'(instr_valid), 32'd1);
        fetch(32'h24);
        check("rc_w9", instr_out, NOP);
        fetch(32'hFC);
        check("rc_w63", instr_out, NOP);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/instr_mem_loadable.md
Name: instr_mem_loadable

Overview:
- Parametrised successor to the fixed 64-word instruction ROM.
- Byte-addressed fetch port with a registered, stall-aware read; address-fault flags.
- Streaming program-load port (valid/ready) replaces hard-coded contents.
- On reset, a sweep state machine clears memory to NOP before any fetch or load; sits between the PC register and the IF/ID pipeline register.

Parameters:
- DEPTH, 64, number of instruction words; power of two, ≥4.
- XLEN, 32, instruction/data width in bits.
- NOP_WORD, 32'h0000_0013, fill and fault-substitute word (addi x0,x0,0).
- AW, $clog2(DEPTH), word-index width (derived, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  async active-low reset.
- load_start  in  1  pulse: begin new program load at word 0.
- load_valid  in  1  load word present.
- load_data  in  XLEN  instruction word to write.
- load_last  in  1  final word of program.
- load_ready  out  1  block accepts load word this cycle.
- load_count  out  AW+1  words written since last load_start.
- pc_in  in  32  byte address of fetch.
- fetch_en  in  1  0 = stall: hold outputs.
- instr_out  out  XLEN  fetched instruction (registered).
- instr_valid  out  1  instr_out is from a RUN-state fetch.
- misaligned  out  1  registered: pc_in[1:0] != 0 at fetch.
- out_of_range  out  1  registered: pc_in >= 4*DEPTH at fetch.
- mem_ready  out  1  FSM in RUN.

Behaviour:
- Reset (async, any state, incl. mid-load/mid-clear): FSM=CLEAR, clear pointer=0, load_count=0; instr_out=NOP_WORD, instr_valid=0, misaligned=0, out_of_range=0, load_ready=0, mem_ready=0. Memory array is not reset directly.
- CLEAR: write NOP_WORD to mem[ptr] each cycle, ptr++; after writing index DEPTH-1 -> RUN. Takes exactly DEPTH cycles after rst_n deassert. load_start ignored.
- RUN: mem_ready=1, load_ready=0. load_start=1 -> LOAD, load_count=0, instr_valid cleared next edge.
- LOAD: load_ready=1 while load_count<DEPTH. Transfer when load_valid&&load_ready: mem[load_count]<=load_data, load_count++. Transfer with load_last=1, or transfer making load_count==DEPTH -> RUN next cycle. Words not loaded keep prior contents (no re-clear). load_start in LOAD restarts load_count=0, same cycle transfer discarded.
- Fetch (RUN only, fetch_en=1): index = pc_in[AW+1:2]; on clock edge instr_out<=mem[index], instr_valid<=1, flags updated. If misaligned or out_of_range: instr_out<=NOP_WORD, flag set, instr_valid still 1. Both flags may be set together.
- Latency: 1 cycle pc_in -> instr_out.
- fetch_en=0: instr_out, instr_valid, flags hold.
- CLEAR/LOAD: instr_out<=NOP_WORD, instr_valid<=0, flags<=0 each edge regardless of fetch_en.
- Write/read same index same cycle impossible (load and fetch are mutually exclusive states).
- load_count saturates at DEPTH; never wraps.

Test Plan:
- Reset release, DEPTH=64: mem_ready rises exactly 64 cycles later; fetch pc=0x20 -> instr_out=0x00000013, instr_valid=1, flags 0.
- load_start, stream 0x40308133,0x005171B3,0x00A10693 (last on 3rd) with load_valid gaps -> load_count=3, RUN; fetch 0x0,0x4,0x8 -> those words in order, one cycle after each pc.
- Fetch pc=0x6 -> misaligned=1, instr_out=NOP; pc=0x100 (DEPTH=64) -> out_of_range=1, NOP; pc=0x102 -> both flags.
- fetch_en=0 for 3 cycles while pc changes 0x0->0x8 -> instr_out holds word from 0x0; re-enable -> word at 0x8 next cycle.
- Load 64 words without load_last -> load_ready drops after 64th, RUN; 65th load_valid not accepted; load_count=64.
- Assert rst_n=0 after 10 load words -> outputs at reset values immediately; CLEAR rerun, then all fetches return NOP_WORD.
